apb_master_bridge: RTL and testbench

//  APB-domain end of the AXI-to-APB bridge. Pops write beats {id, addr, strb, data} from the async

---
 rtl/apb_master_bridge.sv | 150 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   APB-side end of the AXI-to-APB bridge. It pops write beats {id, addr, strb, data}
//   from the write-beat async FIFO and performs one APB4 write per beat. Each completed
//   transfer produces one {id, slverr} push into the response async FIFO, in pop order.
//   Optional feature macro: APB_TIMEOUT_EN. When it is defined, an ACCESS phase that has
//   not seen PREADY_i for TIMEOUT_CYCLES cycles ends with slverr=1.
module apb_master_bridge #(
  parameter int ID_NUM         = 4,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                       PCLK_i,
  input  logic                                       PRESETn_i,
  // write-beat FIFO read port
  input  logic                                       afifo_rvld,
  output logic                                       afifo_rrdy,
  input  logic [ID_NUM+ADDR_W+DATA_W/8+DATA_W-1:0]   afifo_rpayload,
  // APB4 master
  output logic                                       PSEL_o,
  output logic                                       PENABLE_o,
  output logic                                       PWRITE_o,
  output logic [ADDR_W-1:0]                          PADDR_o,
  output logic [DATA_W-1:0]                          PWDATA_o,
  output logic [DATA_W/8-1:0]                        PSTRB_o,
  input  logic                                       PREADY_i,
  input  logic                                       PSLVERR_i,
  // response FIFO write port
  output logic                                       rfifo_wvld,
  input  logic                                       rfifo_wrdy,
  output logic [ID_NUM:0]                            rfifo_wpayload
);

  localparam int STRB_W = DATA_W / 8;
  // Clears the byte-offset bits so every APB address is word aligned.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(STRB_W - 1));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_NUM-1:0]   id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                slverr_q, slverr_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_hit;

  // The current ACCESS cycle is the TIMEOUT_CYCLES-th one without PREADY.
  assign timeout_hit = ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

  // ACCESS-phase watchdog counter.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State and latched-beat registers; reset abandons any in-flight beat.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      strb_q   <= '0;
      data_q   <= '0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      strb_q   <= strb_d;
      data_q   <= data_d;
      slverr_q <= slverr_d;
    end
  end

  // Next-state logic: pop, setup, wait for PREADY, then push the response.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    strb_d   = strb_q;
    data_d   = data_q;
    slverr_d = slverr_q;
`ifdef APB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (afifo_rvld) begin
          {id_d, addr_d, strb_d, data_d} = afifo_rpayload;
          state_d = ST_SETUP;
`ifdef APB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
`ifdef APB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (PREADY_i) begin
          slverr_d = PSLVERR_i;
          state_d  = ST_RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (timeout_hit) begin
          slverr_d = 1'b1;
          state_d  = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (rfifo_wrdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, so PREADY_i never reaches an output.
  assign afifo_rrdy     = (state_q == ST_IDLE) && afifo_rvld;
  assign PSEL_o         = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE_o      = (state_q == ST_ACCESS);
  assign PWRITE_o       = PSEL_o;
  assign PADDR_o        = addr_q & ADDR_MASK;
  assign PWDATA_o       = data_q;
  assign PSTRB_o        = strb_q;
  assign rfifo_wvld     = (state_q == ST_RESP);
  assign rfifo_wpayload = {id_q, slverr_q};

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_apb_master_bridge;

`ifdef APB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 256;
`endif

  logic        clk;
  logic        rst_n;
  logic        afifo_rvld;
  logic        afifo_rrdy;
  logic [51:0] afifo_rpayload;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic        rfifo_wvld, rfifo_wrdy;
  logic [4:0]  rfifo_wpayload;

  int n_vec = 0;
  int n_err = 0;

  apb_master_bridge #(
    .ID_NUM(4), .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .PCLK_i(clk),
    .PRESETn_i(rst_n),
    .afifo_rvld(afifo_rvld),
    .afifo_rrdy(afifo_rrdy),
    .afifo_rpayload(afifo_rpayload),
    .PSEL_o(psel),
    .PENABLE_o(penable),
    .PWRITE_o(pwrite),
    .PADDR_o(paddr),
    .PWDATA_o(pwdata),
    .PSTRB_o(pstrb),
    .PREADY_i(pready),
    .PSLVERR_i(pslverr),
    .rfifo_wvld(rfifo_wvld),
    .rfifo_wrdy(rfifo_wrdy),
    .rfifo_wpayload(rfifo_wpayload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [51:0] beat(input logic [3:0] id, input logic [11:0] addr,
                                       input logic [3:0] strb, input logic [31:0] data);
    return {id, addr, strb, data};
  endfunction

  // One beat with PREADY=1 and free response FIFO; checks each of the four phases.
  task automatic simple_beat(input string tag, input logic [3:0] id, input logic [11:0] addr,
                             input logic [3:0] strb, input logic [31:0] data,
                             input logic [11:0] exp_paddr);
    @(negedge clk);
    afifo_rvld = 1'b1; afifo_rpayload = beat(id, addr, strb, data);
    pready = 1'b1; pslverr = 1'b0; rfifo_wrdy = 1'b1;
    #1;
    chk({tag, ".idle_rrdy"}, 64'(afifo_rrdy), 64'd1);
    chk({tag, ".idle_psel"}, 64'(psel), 64'd0);
    @(negedge clk);
    afifo_rvld = 1'b0;
    #1;
    chk({tag, ".setup_psel"},    64'(psel), 64'd1);
    chk({tag, ".setup_penable"}, 64'(penable), 64'd0);
    chk({tag, ".setup_pwrite"},  64'(pwrite), 64'd1);
    chk({tag, ".setup_paddr"},   64'(paddr), 64'(exp_paddr));
    chk({tag, ".setup_pwdata"},  64'(pwdata), 64'(data));
    chk({tag, ".setup_pstrb"},   64'(pstrb), 64'(strb));
    chk({tag, ".setup_rrdy"},    64'(afifo_rrdy), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, ".access_psel"},    64'(psel), 64'd1);
    chk({tag, ".access_penable"}, 64'(penable), 64'd1);
    chk({tag, ".access_paddr"},   64'(paddr), 64'(exp_paddr));
    chk({tag, ".access_wvld"},    64'(rfifo_wvld), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, ".resp_wvld"},    64'(rfifo_wvld), 64'd1);
    chk({tag, ".resp_payload"}, 64'(rfifo_wpayload), 64'({id, 1'b0}));
    chk({tag, ".resp_psel"},    64'(psel), 64'd0);
    chk({tag, ".resp_penable"}, 64'(penable), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, ".done_wvld"}, 64'(rfifo_wvld), 64'd0);
  endtask

  initial begin
    int ti, ri, qi, n_acc;
    rst_n = 1'b0;
    afifo_rvld = 1'b0; afifo_rpayload = '0;
    pready = 1'b0; pslverr = 1'b0; rfifo_wrdy = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst.psel",    64'(psel), 64'd0);
    chk("rst.penable", 64'(penable), 64'd0);
    chk("rst.pwrite",  64'(pwrite), 64'd0);
    chk("rst.rrdy",    64'(afifo_rrdy), 64'd0);
    chk("rst.wvld",    64'(rfifo_wvld), 64'd0);
    chk("rst.paddr",   64'(paddr), 64'd0);
    chk("rst.pwdata",  64'(pwdata), 64'd0);
    chk("rst.pstrb",   64'(pstrb), 64'd0);
    chk("rst.wpay",    64'(rfifo_wpayload), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: single beat, response 3 cycles after pop
    simple_beat("t1", 4'd3, 12'h104, 4'hF, 32'hDEADBEEF, 12'h104);

    // 2: five wait states then PSLVERR=1
    @(negedge clk);
    afifo_rvld = 1'b1; afifo_rpayload = beat(4'd5, 12'h200, 4'h3, 32'h12345678);
    pready = 1'b0; pslverr = 1'b0; rfifo_wrdy = 1'b1;
    @(negedge clk); afifo_rvld = 1'b0; #1;
    chk("t2.setup_psel", 64'(psel), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin pready = 1'b1; pslverr = 1'b1; end
      #1;
      chk("t2.acc_psel",    64'(psel), 64'd1);
      chk("t2.acc_penable", 64'(penable), 64'd1);
      chk("t2.acc_paddr",   64'(paddr), 64'h200);
      chk("t2.acc_pwdata",  64'(pwdata), 64'h12345678);
      chk("t2.acc_wvld",    64'(rfifo_wvld), 64'd0);
    end
    @(negedge clk); pready = 1'b0; pslverr = 1'b0; #1;
    chk("t2.resp_wvld", 64'(rfifo_wvld), 64'd1);
    chk("t2.resp_pay",  64'(rfifo_wpayload), 64'h0B);
    chk("t2.resp_psel", 64'(psel), 64'd0);
    @(negedge clk); #1;
    chk("t2.done_wvld", 64'(rfifo_wvld), 64'd0);

    // 3: four queued beats processed in order
    ti = 0; ri = 0; qi = 0;
    pready = 1'b1; rfifo_wrdy = 1'b1;
    for (int c = 0; c < 40 && ri < 4; c++) begin
      @(negedge clk);
      afifo_rvld = (qi < 4);
      afifo_rpayload = beat(qi[3:0], 12'(qi * 4), 4'hF, 32'hA000_0000 + 32'(qi));
      #1;
      chk("t3.rrdy_only_idle", 64'(afifo_rrdy && (psel || rfifo_wvld)), 64'd0);
      if (psel && penable) begin
        chk("t3.paddr", 64'(paddr), 64'(ti * 4));
        chk("t3.pwdata", 64'(pwdata), 64'(32'hA000_0000 + 32'(ti)));
        ti++;
      end
      if (rfifo_wvld) begin
        chk("t3.resp_pay", 64'(rfifo_wpayload), 64'({ri[3:0], 1'b0}));
        ri++;
      end
      if (afifo_rvld && afifo_rrdy) qi++;
    end
    chk("t3.transfers", 64'(ti), 64'd4);
    chk("t3.responses", 64'(ri), 64'd4);
    @(negedge clk); afifo_rvld = 1'b0; #1;
    chk("t3.idle_wvld", 64'(rfifo_wvld), 64'd0);

    // 4: response FIFO full for 10 cycles
    @(negedge clk);
    afifo_rvld = 1'b1; afifo_rpayload = beat(4'd6, 12'h010, 4'hF, 32'h11111111);
    rfifo_wrdy = 1'b0; pready = 1'b1;
    @(negedge clk);
    afifo_rpayload = beat(4'd7, 12'h020, 4'hF, 32'h22222222);
    #1;
    chk("t4.setup_rrdy", 64'(afifo_rrdy), 64'd0);
    @(negedge clk); #1;
    chk("t4.access_rrdy", 64'(afifo_rrdy), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) rfifo_wrdy = 1'b1;
      #1;
      chk("t4.hold_wvld", 64'(rfifo_wvld), 64'd1);
      chk("t4.hold_pay",  64'(rfifo_wpayload), 64'h0C);
      chk("t4.hold_rrdy", 64'(afifo_rrdy), 64'd0);
      chk("t4.hold_psel", 64'(psel), 64'd0);
    end
    @(negedge clk); #1;
    chk("t4.b2_idle_wvld", 64'(rfifo_wvld), 64'd0);
    chk("t4.b2_rrdy",      64'(afifo_rrdy), 64'd1);
    @(negedge clk); afifo_rvld = 1'b0; #1;
    chk("t4.b2_setup_psel",  64'(psel), 64'd1);
    chk("t4.b2_setup_paddr", 64'(paddr), 64'h020);
    @(negedge clk); #1;
    chk("t4.b2_access_pen", 64'(penable), 64'd1);
    @(negedge clk); #1;
    chk("t4.b2_resp_pay", 64'(rfifo_wpayload), 64'h0E);
    @(negedge clk); #1;
    chk("t4.b2_done_wvld", 64'(rfifo_wvld), 64'd0);

    // 5: unaligned address and zero strobe
    simple_beat("t5", 4'd9, 12'h107, 4'h0, 32'hA5A5A5A5, 12'h104);

    // 6: reset during ACCESS, then a clean beat
    @(negedge clk);
    afifo_rvld = 1'b1; afifo_rpayload = beat(4'd2, 12'h300, 4'hF, 32'h33333333);
    pready = 1'b0; rfifo_wrdy = 1'b1;
    @(negedge clk); afifo_rvld = 1'b0;
    @(negedge clk); #1;
    chk("t6.pre_penable", 64'(penable), 64'd1);
    #1; rst_n = 1'b0; #1;
    chk("t6.rst_psel",    64'(psel), 64'd0);
    chk("t6.rst_penable", 64'(penable), 64'd0);
    chk("t6.rst_wvld",    64'(rfifo_wvld), 64'd0);
    chk("t6.rst_paddr",   64'(paddr), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("t6.post_wvld", 64'(rfifo_wvld), 64'd0);
    chk("t6.post_psel", 64'(psel), 64'd0);
    simple_beat("t6b", 4'd1, 12'h044, 4'hC, 32'h44444444, 12'h044);

`ifdef APB_TIMEOUT_EN
    // Timeout: PREADY stuck low
    @(negedge clk);
    afifo_rvld = 1'b1; afifo_rpayload = beat(4'd4, 12'h080, 4'hF, 32'h55555555);
    pready = 1'b0; rfifo_wrdy = 1'b1;
    @(negedge clk); afifo_rvld = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (rfifo_wvld) break;
      if (penable) n_acc++;
    end
    chk("to.access_cycles", 64'(n_acc), 64'd16);
    chk("to.resp_wvld", 64'(rfifo_wvld), 64'd1);
    chk("to.resp_pay",  64'(rfifo_wpayload), 64'h09);
    chk("to.resp_psel", 64'(psel), 64'd0);
`else
    n_acc = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
